flow_ctrl: RTL and testbench

FLOW_CTRL -- requirements
Module: flow_ctrl

---
 rtl/flow_ctrl_pkg.sv | 35 +++
 rtl/flow_ctrl_cond_eval.sv | 27 ++
 rtl/flow_ctrl.sv | 131 +++++++++++++
 tb/tb_flow_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the flow-control unit: opcodes, condition selects,
// FSM states and the ALU flag bundle.
package flow_ctrl_pkg;

    // Opcode field values (Instruction[2:0]); all other values are no-ops here
    localparam logic [2:0] kRSH  = 3'd1;
    localparam logic [2:0] kJMP  = 3'd2;
    localparam logic [2:0] kBR   = 3'd3;
    localparam logic [2:0] kLOOP = 3'd4;
    localparam logic [2:0] kLDC  = 3'd5;

    // Condition select field (Instruction[5:3])
    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_Z      = 3'd1,
        COND_NZ     = 3'd2,
        COND_EVEN   = 3'd3,
        COND_NEVEN  = 3'd4,
        COND_EQ     = 3'd5,
        COND_NEQ    = 3'd6,
        COND_NEVER  = 3'd7
    } cond_sel_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic z;
        logic e;
        logic q;
    } flags_t;

endpackage

// File: rtl/flow_ctrl_cond_eval.sv
// Combinational condition evaluator: maps a condition select and a flag set
// to a single taken bit.
module cond_eval
    import flow_ctrl_pkg::*;
(
    input  cond_sel_e sel,
    input  flags_t    flags,
    output logic      taken
);

    // Decode the condition select against the supplied flags
    always_comb begin
        taken = 1'b0;
        case (sel)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = flags.z;
            COND_NZ:     taken = ~flags.z;
            COND_EVEN:   taken = flags.e;
            COND_NEVEN:  taken = ~flags.e;
            COND_EQ:     taken = flags.q;
            COND_NEQ:    taken = ~flags.q;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flow_ctrl.sv
// Flow-control unit: decodes jump/branch/loop instructions, holds the ALU
// flag register and loop counter, and produces a flush window after every
// taken transfer during which new instructions are ignored.
module flow_ctrl
    import flow_ctrl_pkg::*;
#(
    parameter int IW           = 9,
    parameter int DW           = 8,
    parameter int FLUSH_CYCLES = 1,
    parameter int LEGACY       = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [IW-1:0] Instruction,
    input  logic          instr_valid,
    input  logic          flag_we,
    input  logic          ZERO,
    input  logic          BEVEN,
    input  logic          EQ,
    input  logic [DW-1:0] alu_result,
    output logic          jump_en,
    output logic          branch_en,
    output logic          flush,
    output logic          busy,
    output logic [DW-1:0] loop_cnt
);

    localparam logic [2:0]    FLUSH_LAST = 3'(FLUSH_CYCLES);
    localparam logic [DW-1:0] CNT_ONE    = {{(DW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    flags_t        flags_q, flags_d;
    flags_t        flags_fwd;
    logic [DW-1:0] loop_cnt_q, loop_cnt_d;
    logic [2:0]    fcnt_q, fcnt_d;
    logic          jump_en_q, jump_en_d;
    logic          branch_en_q, branch_en_d;
    logic          flush_q, flush_d;
    logic          busy_q, busy_d;
    logic [2:0]    opcode;
    logic          cond_taken;

    assign opcode = Instruction[2:0];

    // Flags written this cycle are seen by the instruction in the same cycle
    assign flags_fwd = flag_we ? flags_t'{z: ZERO, e: BEVEN, q: EQ} : flags_q;

    cond_eval u_cond_eval (
        .sel   (cond_sel_e'(Instruction[5:3])),
        .flags (flags_fwd),
        .taken (cond_taken)
    );

    // Next-state decode: instruction acceptance in IDLE, flush-window counting in FLUSH
    always_comb begin
        state_d     = state_q;
        flags_d     = flags_fwd;
        loop_cnt_d  = loop_cnt_q;
        fcnt_d      = fcnt_q;
        jump_en_d   = 1'b0;
        branch_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    case (opcode)
                        kJMP: jump_en_d = 1'b1;
                        kBR:  branch_en_d = cond_taken;
                        kLOOP: begin
                            // A zero counter is terminal: never wrap around
                            if (loop_cnt_q != '0) begin
                                loop_cnt_d  = loop_cnt_q - CNT_ONE;
                                branch_en_d = 1'b1;
                            end
                        end
                        kLDC: loop_cnt_d = alu_result;
                        kRSH: jump_en_d = (LEGACY != 0) && flags_fwd.z;
                        default: ;
                    endcase
                end
                if (jump_en_d || branch_en_d) begin
                    state_d = FLUSH;
                    fcnt_d  = 3'd1;
                end
            end
            FLUSH: begin
                if (fcnt_q == FLUSH_LAST) begin
                    state_d = IDLE;
                    fcnt_d  = 3'd0;
                end else begin
                    fcnt_d = fcnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = 3'd0;
            end
        endcase
        flush_d = (state_d == FLUSH);
        busy_d  = (state_d == FLUSH);
    end

    // State, flag, counter and registered-output update with asynchronous clear
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            flags_q     <= '0;
            loop_cnt_q  <= '0;
            fcnt_q      <= 3'd0;
            jump_en_q   <= 1'b0;
            branch_en_q <= 1'b0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            loop_cnt_q  <= loop_cnt_d;
            fcnt_q      <= fcnt_d;
            jump_en_q   <= jump_en_d;
            branch_en_q <= branch_en_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
        end
    end

    assign jump_en   = jump_en_q;
    assign branch_en = branch_en_q;
    assign flush     = flush_q;
    assign busy      = busy_q;
    assign loop_cnt  = loop_cnt_q;

endmodule

// File: tb/tb_flow_ctrl.sv
// Bench for flow_ctrl: three instances (default, long flush, legacy off)
// share one directed stimulus stream and are checked against a
// cycle-level reference model plus literal expectations.
module tb_flow_ctrl;
    import flow_ctrl_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [8:0] Instruction = '0;
    logic       instr_valid = 1'b0;
    logic       flag_we = 1'b0;
    logic       ZERO = 1'b0, BEVEN = 1'b0, EQ = 1'b0;
    logic [7:0] alu_result = '0;

    logic [2:0]      jmp_w, brn_w, fl_w, bsy_w;
    logic [2:0][7:0] cnt_w;

    int tests = 0;
    int fails = 0;

    // Per-instance configuration: 0 = defaults, 1 = FLUSH_CYCLES 3, 2 = LEGACY 0
    int FCa [3] = '{1, 3, 1};
    bit LEGa[3] = '{1'b1, 1'b1, 1'b0};

    always #5 Clk = ~Clk;

    flow_ctrl #(.IW(9), .DW(8), .FLUSH_CYCLES(1), .LEGACY(1)) dut0 (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .instr_valid(instr_valid),
        .flag_we(flag_we), .ZERO(ZERO), .BEVEN(BEVEN), .EQ(EQ), .alu_result(alu_result),
        .jump_en(jmp_w[0]), .branch_en(brn_w[0]), .flush(fl_w[0]), .busy(bsy_w[0]),
        .loop_cnt(cnt_w[0]));

    flow_ctrl #(.IW(9), .DW(8), .FLUSH_CYCLES(3), .LEGACY(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .instr_valid(instr_valid),
        .flag_we(flag_we), .ZERO(ZERO), .BEVEN(BEVEN), .EQ(EQ), .alu_result(alu_result),
        .jump_en(jmp_w[1]), .branch_en(brn_w[1]), .flush(fl_w[1]), .busy(bsy_w[1]),
        .loop_cnt(cnt_w[1]));

    flow_ctrl #(.IW(9), .DW(8), .FLUSH_CYCLES(1), .LEGACY(0)) dut2 (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .instr_valid(instr_valid),
        .flag_we(flag_we), .ZERO(ZERO), .BEVEN(BEVEN), .EQ(EQ), .alu_result(alu_result),
        .jump_en(jmp_w[2]), .branch_en(brn_w[2]), .flush(fl_w[2]), .busy(bsy_w[2]),
        .loop_cnt(cnt_w[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: flags {z,e,q}, loop count, remaining flush cycles, pending pulses
    logic [2:0] mf [3];
    logic [7:0] mc [3];
    int         mr [3];
    logic       mj [3];
    logic       mb [3];

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 3; i++) begin
                mf[i] <= '0; mc[i] <= '0; mr[i] <= 0; mj[i] <= 1'b0; mb[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic z, e, q, tj, tb;
                logic [7:0] tbl, nc;
                logic [2:0] op, cs;
                z  = flag_we ? ZERO  : mf[i][2];
                e  = flag_we ? BEVEN : mf[i][1];
                q  = flag_we ? EQ    : mf[i][0];
                tj = 1'b0; tb = 1'b0; nc = mc[i];
                op = Instruction[2:0];
                cs = Instruction[5:3];
                // bit n = truth of condition select n
                tbl = {1'b0, ~q, q, ~e, e, ~z, z, 1'b1};
                if (mr[i] == 0 && instr_valid) begin
                    if (op == kJMP) tj = 1'b1;
                    else if (op == kBR) tb = tbl[cs];
                    else if (op == kLOOP && mc[i] != 0) begin tb = 1'b1; nc = mc[i] - 8'd1; end
                    else if (op == kLDC) nc = alu_result;
                    else if (op == kRSH && LEGa[i] && z) tj = 1'b1;
                end
                mj[i] <= tj;
                mb[i] <= tb;
                mc[i] <= nc;
                mr[i] <= (tj || tb) ? FCa[i] : ((mr[i] > 0) ? mr[i] - 1 : 0);
                mf[i] <= flag_we ? {ZERO, BEVEN, EQ} : mf[i];
            end
        end
    end

    // Every-cycle comparison of all instances against the model
    always @(negedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("jump_en[%0d]", i),   32'(jmp_w[i]), 32'(mj[i]));
                chk($sformatf("branch_en[%0d]", i), 32'(brn_w[i]), 32'(mb[i]));
                chk($sformatf("flush[%0d]", i),     32'(fl_w[i]),  32'(mr[i] > 0));
                chk($sformatf("busy[%0d]", i),      32'(bsy_w[i]), 32'(mr[i] > 0));
                chk($sformatf("loop_cnt[%0d]", i),  32'(cnt_w[i]), 32'(mc[i]));
                chk($sformatf("excl[%0d]", i),      32'(jmp_w[i] & brn_w[i]), 32'd0);
            end
        end
    end

    // Apply one cycle of inputs, then return 1 time unit after the sampling edge
    task automatic drive(input logic [2:0] op, input logic [2:0] cs, input logic v,
                         input logic we, input logic z, input logic e, input logic q,
                         input logic [7:0] alu);
        Instruction = {3'b000, cs, op};
        instr_valid = v;
        flag_we     = we;
        ZERO = z; BEVEN = e; EQ = q;
        alu_result  = alu;
        @(posedge Clk);
        #1;
        instr_valid = 1'b0;
        flag_we     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic instr(input logic [2:0] op, input logic [2:0] cs);
        drive(op, cs, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_jump",   32'(jmp_w), 32'd0);
        chk("rst_branch", 32'(brn_w), 32'd0);
        chk("rst_flush",  32'(fl_w),  32'd0);
        chk("rst_busy",   32'(bsy_w), 32'd0);
        chk("rst_cnt0",   32'(cnt_w[0]), 32'd0);
        Reset = 1'b0;

        // Forwarded Z=1 with kBR cond Z, first instruction after reset
        drive(kBR, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        chk("fwd_branch0", 32'(brn_w[0]), 32'd1);
        chk("fwd_flush0",  32'(fl_w[0]),  32'd1);
        chk("fwd_jump0",   32'(jmp_w[0]), 32'd0);
        idle(1);
        chk("fwd_branch0_end", 32'(brn_w[0]), 32'd0);
        chk("fwd_flush0_end",  32'(fl_w[0]),  32'd0);
        chk("fwd_busy1_mid",   32'(bsy_w[1]), 32'd1);
        idle(3);

        // Never condition with all flags set, and !EVEN against set EVEN
        drive(kBR, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        chk("never_branch", 32'(brn_w), 32'd0);
        chk("never_flush",  32'(fl_w),  32'd0);
        instr(kBR, 3'd4);
        chk("neven_branch", 32'(brn_w), 32'd0);
        // Registered EVEN used when flag_we is low
        drive(3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        instr(kBR, 3'd3);
        chk("reg_even_branch0", 32'(brn_w[0]), 32'd1);
        idle(4);

        // Loop count: load 3, loop four times
        drive(kLDC, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        chk("ldc_cnt0",   32'(cnt_w[0]), 32'd3);
        chk("ldc_branch", 32'(brn_w), 32'd0);
        for (int k = 0; k < 4; k++) begin
            instr(kLOOP, 3'd0);
            chk($sformatf("loop_cnt0_%0d", k),    32'(cnt_w[0]), 32'((k < 3) ? 2 - k : 0));
            chk($sformatf("loop_branch0_%0d", k), 32'(brn_w[0]), 32'(k < 3));
            idle(3);
        end

        // Flush length on the FLUSH_CYCLES=3 instance; second kJMP lands in its flush
        instr(kJMP, 3'd0);
        chk("jmp_jump1",  32'(jmp_w[1]), 32'd1);
        chk("jmp_busy1",  32'(bsy_w[1]), 32'd1);
        idle(1);
        chk("jmp_jump1_c2",  32'(jmp_w[1]), 32'd0);
        chk("jmp_flush1_c2", 32'(fl_w[1]),  32'd1);
        instr(kJMP, 3'd0);
        chk("jmp_ignored1",  32'(jmp_w[1]), 32'd0);
        chk("jmp_flush1_c3", 32'(fl_w[1]),  32'd1);
        chk("jmp_taken0",    32'(jmp_w[0]), 32'd1);
        idle(1);
        chk("jmp_flush1_end", 32'(fl_w[1]),  32'd0);
        chk("jmp_busy1_end",  32'(bsy_w[1]), 32'd0);
        idle(3);

        // Legacy RSH with forwarded Z=1, then with registered Z=0, then an unused opcode
        drive(kRSH, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        chk("rsh_jump0",  32'(jmp_w[0]), 32'd1);
        chk("rsh_jump2",  32'(jmp_w[2]), 32'd0);
        chk("rsh_flush2", 32'(fl_w[2]),  32'd0);
        idle(4);
        drive(3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        instr(kRSH, 3'd0);
        chk("rsh_nz_jump0", 32'(jmp_w[0]), 32'd0);
        instr(3'd6, 3'd0);
        chk("other_op", 32'({jmp_w, brn_w, fl_w}), 32'd0);
        idle(1);

        // Reset during the second flush cycle of the long-flush instance
        drive(kLDC, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        instr(kJMP, 3'd0);
        idle(1);
        chk("pre_rst_flush1", 32'(fl_w[1]), 32'd1);
        Reset = 1'b1;
        #1;
        chk("rst_mid_jump",   32'(jmp_w), 32'd0);
        chk("rst_mid_branch", 32'(brn_w), 32'd0);
        chk("rst_mid_flush",  32'(fl_w),  32'd0);
        chk("rst_mid_busy",   32'(bsy_w), 32'd0);
        chk("rst_mid_cnt1",   32'(cnt_w[1]), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        instr(kJMP, 3'd0);
        chk("post_rst_jump1", 32'(jmp_w[1]), 32'd1);
        chk("post_rst_busy1", 32'(bsy_w[1]), 32'd1);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
